// File: rtl/motion_pkg.sv
// Shared types and constants for the vertical position integrator.
package motion_pkg;

  typedef enum logic [1:0] {
    GROUNDED = 2'd0,
    AIRBORNE = 2'd1,
    DEAD     = 2'd2
  } vm_state_t;

  localparam logic [7:0] KEY_JUMP   = 8'h1A;
  localparam int         Y_W        = 10;
  localparam logic [9:0] FLOOR_NONE = 10'd511;
  localparam int         VEL_MAX    = 31;
  localparam int         VEL_MIN    = -32;

  // Clamp the jump FSM velocity into the 12-bit position arithmetic range.
  function automatic logic signed [11:0] sat_vel(input logic signed [31:0] v);
    if (v > 32'(VEL_MAX))      return 12'(VEL_MAX);
    else if (v < 32'(VEL_MIN)) return 12'(VEL_MIN);
    else                       return v[11:0];
  endfunction

endpackage

// File: rtl/vertical_motion_if.sv
// Frame-rate motion bus between the jump FSM side (master) and the integrator (slave).
interface vertical_motion_if;
  import motion_pkg::*;

  logic                  frame_tick;
  logic signed [31:0]    Y_Velocity;
  logic [Y_W-1:0]        floor_y;
  logic [Y_W-1:0]        ceiling_y;
  logic [7:0]            keycode;
  logic [7:0]            keycode2;
  logic [Y_W-1:0]        Ball_Y_Pos;
  logic                  current_jumping;
  logic                  landed;
  logic                  head_bump;
  logic                  out_of_bounds;

  modport master (
    output frame_tick, Y_Velocity, floor_y, ceiling_y, keycode, keycode2,
    input  Ball_Y_Pos, current_jumping, landed, head_bump, out_of_bounds
  );

  modport slave (
    input  frame_tick, Y_Velocity, floor_y, ceiling_y, keycode, keycode2,
    output Ball_Y_Pos, current_jumping, landed, head_bump, out_of_bounds
  );

endinterface

// File: rtl/vertical_motion_pkg_unused_guard.sv
// Empty guard cell instantiated by the integrator to keep its hierarchy stable.
module vertical_motion_pkg_unused_guard;
endmodule

// File: rtl/vertical_motion.sv
// Per-frame vertical integrator: advances sprite Y, resolves landing, ceiling bumps and fall-out.
// States: GROUNDED = on a floor | AIRBORNE = integrating velocity | DEAD = fell out, frozen until reset
module vertical_motion
  import motion_pkg::*;
#(
  parameter int Y_START  = 400,
  parameter int SPRITE_H = 32,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 479
) (
  input logic              Clk,
  input logic              Reset,
  vertical_motion_if.slave vm
);

  localparam logic signed [11:0] H_S    = 12'(SPRITE_H);
  localparam logic signed [11:0] YMIN_S = 12'(Y_MIN);
  localparam logic signed [11:0] YMAX_S = 12'(Y_MAX);

  vertical_motion_pkg_unused_guard u_guard_dummy ();

  vm_state_t      state_q;
  logic [Y_W-1:0] pos_q;
  logic           jumping_q;
  logic           landed_q;
  logic           bump_q;
  logic           oob_q;
  logic           armed_q;
  logic           bumped_q;

  logic                jump_key;
  logic                vel_nonneg;
  logic signed [11:0]  vel_s;
  logic signed [11:0]  pos_s;
  logic signed [11:0]  next_y;
  logic signed [11:0]  bottom;
  logic signed [11:0]  floor_s;
  logic signed [11:0]  ceil_s;
  logic signed [11:0]  ceil_lim;
  logic                land;
  logic [Y_W-1:0]      land_y;

  always_comb begin
    jump_key   = (vm.keycode == KEY_JUMP) || (vm.keycode2 == KEY_JUMP);
    vel_nonneg = ~vm.Y_Velocity[31];
    vel_s      = sat_vel(vm.Y_Velocity);
    pos_s      = {2'b00, pos_q};
    next_y     = pos_s + vel_s;
    bottom     = next_y + H_S;
    floor_s    = {2'b00, vm.floor_y};
    ceil_s     = {2'b00, vm.ceiling_y};
    ceil_lim   = (ceil_s > YMIN_S) ? ceil_s : YMIN_S;
    land       = vel_nonneg && (bottom >= floor_s) && (floor_s <= YMAX_S);
    land_y     = vm.floor_y - Y_W'(SPRITE_H);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= GROUNDED;
      pos_q     <= Y_W'(Y_START);
      jumping_q <= 1'b0;
      landed_q  <= 1'b0;
      bump_q    <= 1'b0;
      oob_q     <= 1'b0;
      armed_q   <= 1'b0;
      bumped_q  <= 1'b0;
    end else begin
      // Event pulses last exactly one Clk, independent of the tick rate.
      landed_q <= 1'b0;
      bump_q   <= 1'b0;
      if (vm.frame_tick) begin
        unique case (state_q)
          GROUNDED: begin
            if (!jump_key) armed_q <= 1'b1;
            if (armed_q && jump_key) begin
              state_q   <= AIRBORNE;
              jumping_q <= 1'b1;
              armed_q   <= 1'b0;
            end else if (floor_s > pos_s + H_S) begin
              state_q   <= AIRBORNE;
              jumping_q <= 1'b1;
            end
          end
          AIRBORNE: begin
            if (vel_nonneg) bumped_q <= 1'b0;
            if (land) begin
              pos_q     <= land_y;
              state_q   <= GROUNDED;
              jumping_q <= 1'b0;
              landed_q  <= 1'b1;
              bumped_q  <= 1'b0;
              armed_q   <= 1'b0;
            end else if (bottom > YMAX_S) begin
              state_q   <= DEAD;
              oob_q     <= 1'b1;
              jumping_q <= 1'b0;
            end else if (!vel_nonneg && (next_y < ceil_lim)) begin
              pos_q <= ceil_lim[Y_W-1:0];
              if (!bumped_q) begin
                bump_q   <= 1'b1;
                bumped_q <= 1'b1;
              end
            end else begin
              pos_q <= next_y[Y_W-1:0];
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign vm.Ball_Y_Pos      = pos_q;
  assign vm.current_jumping = jumping_q;
  assign vm.landed          = landed_q;
  assign vm.head_bump       = bump_q;
  assign vm.out_of_bounds   = oob_q;

endmodule

// File: tb/tb_vertical_motion.sv
// Directed self-checking bench for vertical_motion.
module tb_vertical_motion;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  vertical_motion_if vif ();

  vertical_motion dut (
    .Clk   (clk),
    .Reset (reset),
    .vm    (vif)
  );

  always #5 clk = ~clk;

  task automatic tick(input int vel);
    vif.Y_Velocity = vel;
    vif.frame_tick = 1'b1;
    @(negedge clk);
    vif.frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    vif.frame_tick = 1'b0;
    vif.Y_Velocity = 0;
    vif.floor_y    = 10'd432;
    vif.ceiling_y  = 10'd0;
    vif.keycode    = 8'h00;
    vif.keycode2   = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (vif.Ball_Y_Pos !== 10'd400) begin errors++; $display("FAIL rst_y got %0d exp 400", vif.Ball_Y_Pos); end
    checks++; if (vif.current_jumping !== 1'b0) begin errors++; $display("FAIL rst_jump got %0b exp 0", vif.current_jumping); end
    checks++; if ({vif.landed, vif.head_bump, vif.out_of_bounds} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {vif.landed, vif.head_bump, vif.out_of_bounds}); end
    // floor exactly at sprite bottom keeps it grounded
    tick(0);
    checks++; if (vif.current_jumping !== 1'b0 || vif.Ball_Y_Pos !== 10'd400) begin errors++; $display("FAIL floor_equal got j=%0b y=%0d exp j=0 y=400", vif.current_jumping, vif.Ball_Y_Pos); end
  endtask

  task automatic test_launch();
    vif.keycode = 8'h00;
    tick(0);
    vif.keycode2 = 8'h1A;
    tick(-10);
    checks++; if (vif.current_jumping !== 1'b1 || vif.Ball_Y_Pos !== 10'd400) begin errors++; $display("FAIL launch got j=%0b y=%0d exp j=1 y=400", vif.current_jumping, vif.Ball_Y_Pos); end
    vif.keycode2 = 8'h00;
    tick(-10);
    checks++; if (vif.Ball_Y_Pos !== 10'd390) begin errors++; $display("FAIL rise1 got %0d exp 390", vif.Ball_Y_Pos); end
    tick(-8);
    checks++; if (vif.Ball_Y_Pos !== 10'd382) begin errors++; $display("FAIL rise2 got %0d exp 382", vif.Ball_Y_Pos); end
    vif.Y_Velocity = -8;
    repeat (4) @(negedge clk);
    checks++; if (vif.Ball_Y_Pos !== 10'd382) begin errors++; $display("FAIL no_tick_hold got %0d exp 382", vif.Ball_Y_Pos); end
  endtask

  task automatic test_land_rearm();
    tick(7);
    tick(7);
    checks++; if (vif.Ball_Y_Pos !== 10'd396) begin errors++; $display("FAIL fall got %0d exp 396", vif.Ball_Y_Pos); end
    tick(0);
    checks++; if (vif.Ball_Y_Pos !== 10'd396 || vif.current_jumping !== 1'b1 || vif.landed !== 1'b0) begin errors++; $display("FAIL zero_vel got y=%0d j=%0b l=%0b exp y=396 j=1 l=0", vif.Ball_Y_Pos, vif.current_jumping, vif.landed); end
    vif.keycode = 8'h1A;
    tick(6);
    checks++; if (vif.Ball_Y_Pos !== 10'd400 || vif.current_jumping !== 1'b0 || vif.landed !== 1'b1) begin errors++; $display("FAIL land got y=%0d j=%0b l=%0b exp y=400 j=0 l=1", vif.Ball_Y_Pos, vif.current_jumping, vif.landed); end
    @(negedge clk);
    checks++; if (vif.landed !== 1'b0) begin errors++; $display("FAIL land_pulse got %0b exp 0", vif.landed); end
    tick(0);
    tick(0);
    checks++; if (vif.current_jumping !== 1'b0) begin errors++; $display("FAIL held_key_relaunch got %0b exp 0", vif.current_jumping); end
    vif.keycode = 8'h00;
    tick(0);
    checks++; if (vif.current_jumping !== 1'b0) begin errors++; $display("FAIL release got %0b exp 0", vif.current_jumping); end
    vif.keycode = 8'h1A;
    tick(0);
    checks++; if (vif.current_jumping !== 1'b1 || vif.Ball_Y_Pos !== 10'd400) begin errors++; $display("FAIL relaunch got j=%0b y=%0d exp j=1 y=400", vif.current_jumping, vif.Ball_Y_Pos); end
    vif.keycode = 8'h00;
  endtask

  task automatic test_ceiling();
    tick(-15);
    checks++; if (vif.Ball_Y_Pos !== 10'd385) begin errors++; $display("FAIL pre_ceil got %0d exp 385", vif.Ball_Y_Pos); end
    vif.ceiling_y = 10'd380;
    tick(-8);
    checks++; if (vif.Ball_Y_Pos !== 10'd380 || vif.head_bump !== 1'b1) begin errors++; $display("FAIL bump got y=%0d hb=%0b exp y=380 hb=1", vif.Ball_Y_Pos, vif.head_bump); end
    @(negedge clk);
    checks++; if (vif.head_bump !== 1'b0) begin errors++; $display("FAIL bump_pulse got %0b exp 0", vif.head_bump); end
    vif.Y_Velocity = -7;
    vif.frame_tick = 1'b1;
    @(negedge clk);
    vif.frame_tick = 1'b0;
    checks++; if (vif.Ball_Y_Pos !== 10'd380 || vif.head_bump !== 1'b0) begin errors++; $display("FAIL rebump got y=%0d hb=%0b exp y=380 hb=0", vif.Ball_Y_Pos, vif.head_bump); end
    tick(1);
    checks++; if (vif.Ball_Y_Pos !== 10'd381) begin errors++; $display("FAIL descend got %0d exp 381", vif.Ball_Y_Pos); end
    tick(-5);
    checks++; if (vif.Ball_Y_Pos !== 10'd380 || vif.head_bump !== 1'b1) begin errors++; $display("FAIL bump_rearm got y=%0d hb=%0b exp y=380 hb=1", vif.Ball_Y_Pos, vif.head_bump); end
    vif.ceiling_y = 10'd0;
    tick(20);
    checks++; if (vif.Ball_Y_Pos !== 10'd400 || vif.current_jumping !== 1'b0) begin errors++; $display("FAIL land2 got y=%0d j=%0b exp y=400 j=0", vif.Ball_Y_Pos, vif.current_jumping); end
  endtask

  task automatic test_walkoff_fall();
    vif.floor_y = 10'd511;
    tick(6);
    checks++; if (vif.current_jumping !== 1'b1 || vif.Ball_Y_Pos !== 10'd400) begin errors++; $display("FAIL walkoff got j=%0b y=%0d exp j=1 y=400", vif.current_jumping, vif.Ball_Y_Pos); end
    for (int i = 0; i < 7; i++) tick(6);
    checks++; if (vif.Ball_Y_Pos !== 10'd442 || vif.out_of_bounds !== 1'b0) begin errors++; $display("FAIL edge_y got y=%0d oob=%0b exp y=442 oob=0", vif.Ball_Y_Pos, vif.out_of_bounds); end
    tick(6);
    checks++; if (vif.out_of_bounds !== 1'b1 || vif.current_jumping !== 1'b0 || vif.Ball_Y_Pos !== 10'd442) begin errors++; $display("FAIL dead got oob=%0b j=%0b y=%0d exp 1 0 442", vif.out_of_bounds, vif.current_jumping, vif.Ball_Y_Pos); end
    vif.keycode = 8'h1A;
    vif.floor_y = 10'd432;
    tick(-10);
    tick(-10);
    checks++; if (vif.out_of_bounds !== 1'b1 || vif.current_jumping !== 1'b0 || vif.Ball_Y_Pos !== 10'd442) begin errors++; $display("FAIL dead_hold got oob=%0b j=%0b y=%0d exp 1 0 442", vif.out_of_bounds, vif.current_jumping, vif.Ball_Y_Pos); end
    vif.keycode = 8'h00;
  endtask

  task automatic test_saturation();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (vif.out_of_bounds !== 1'b0 || vif.Ball_Y_Pos !== 10'd400) begin errors++; $display("FAIL dead_reset got oob=%0b y=%0d exp 0 400", vif.out_of_bounds, vif.Ball_Y_Pos); end
    vif.floor_y = 10'd511;
    tick(0);
    tick(1000);
    checks++; if (vif.Ball_Y_Pos !== 10'd431) begin errors++; $display("FAIL sat_pos got %0d exp 431", vif.Ball_Y_Pos); end
    tick(1000);
    checks++; if (vif.out_of_bounds !== 1'b1 || vif.Ball_Y_Pos !== 10'd431) begin errors++; $display("FAIL sat_dead got oob=%0b y=%0d exp 1 431", vif.out_of_bounds, vif.Ball_Y_Pos); end
  endtask

  task automatic test_reset_midair();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tick(0);
    tick(-100);
    checks++; if (vif.Ball_Y_Pos !== 10'd368) begin errors++; $display("FAIL sat_neg got %0d exp 368", vif.Ball_Y_Pos); end
    tick(-100);
    tick(-100);
    tick(-4);
    checks++; if (vif.Ball_Y_Pos !== 10'd300 || vif.current_jumping !== 1'b1) begin errors++; $display("FAIL midair got y=%0d j=%0b exp 300 1", vif.Ball_Y_Pos, vif.current_jumping); end
    reset = 1'b1;
    vif.Y_Velocity = -10;
    vif.frame_tick = 1'b1;
    @(negedge clk);
    vif.frame_tick = 1'b0;
    reset = 1'b0;
    checks++; if (vif.Ball_Y_Pos !== 10'd400 || vif.current_jumping !== 1'b0 || vif.out_of_bounds !== 1'b0) begin errors++; $display("FAIL reset_midair got y=%0d j=%0b oob=%0b exp 400 0 0", vif.Ball_Y_Pos, vif.current_jumping, vif.out_of_bounds); end
  endtask

  initial begin
    test_reset();
    test_launch();
    test_land_rearm();
    test_ceiling();
    test_walkoff_fall();
    test_saturation();
    test_reset_midair();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
